// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its queue.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'd0;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with single-cycle flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only allowed when the head leaves in the same cycle.
  assign do_pop_c  = pop_i && !flush_i && !empty_o;
  assign do_push_c = push_i && !flush_i && (!full_o || do_pop_c);

  // Pointer and occupancy update; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push_c && !do_pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_push_c && do_pop_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_c) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, boot FSM, next-PC mux and fetch-queue control.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       FQ_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_c;
  logic              pop_c;
  logic              fetch_c;
  fetch_entry_t      push_entry_c;
  fetch_entry_t      fq_head;
  logic [CNT_W-1:0]  fq_count;
  logic              fq_empty;
  logic              fq_full;

  assign rom_address = pc_q;
  assign pc_plus4_c  = pc_q + ADDR_W'(PC_STEP);

  // A pop coinciding with a redirect is discarded together with the flush.
  assign pop_c   = id_valid && id_ready && !redirect;
  assign fetch_c = (state_q == RUN) && !redirect && (!fq_full || pop_c);

  assign push_entry_c = '{instruction: rom_instruction, pc_plus4: pc_plus4_c};

  // Decode sees zeros whenever the queue is empty.
  assign id_valid       = (fq_count != '0);
  assign id_instruction = fq_empty ? NOP_INSTR : fq_head.instruction;
  assign id_pc_plus4    = fq_empty ? '0 : fq_head.pc_plus4;

  // Next state and next PC: redirect, then sequential fetch, else hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      pc_d = align_pc(redirect_pc);
    end else if (fetch_c) begin
      pc_d = pc_plus4_c;
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock_i     (clock),
    .reset_i     (reset),
    .flush_i     (redirect),
    .push_i      (fetch_c),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .head_o      (fq_head),
    .count_o     (fq_count),
    .empty_o     (fq_empty),
    .full_o      (fq_full)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed stimulus, decoupled pop monitor.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  always #5 clock = ~clock;

  // Standard boot ROM; other addresses return a recognisable address-derived word.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8001_060A;
      32'h4:   return 32'h0000_0000;
      32'h8:   return 32'h0000_0000;
      32'hC:   return 32'h0401_1000;
      default: return 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign rom_instruction = rom_word(rom_address);

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instruction  (id_instruction),
    .id_pc_plus4     (id_pc_plus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back('{instruction: instr, pc_plus4: pc4});
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rom_address"}, rom_address, 32'h0);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'h0);
    chk({tag, "_id_instruction"}, id_instruction, 32'h0);
    chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h0);
  endtask

  // Boot from an asserted reset with id_ready=1; leaves the queue full and stalled.
  task automatic boot_seq(input string tag);
    tick();
    redirect = 1'b0;
    id_ready = 1'b1;
    push_exp(32'h8001_060A, 32'd4);
    push_exp(32'h0000_0000, 32'd8);
    push_exp(32'h0000_0000, 32'd12);
    push_exp(32'h0401_1000, 32'd16);
    reset = 1'b0;
    chk({tag, "_addr_boot"}, rom_address, 32'd0);
    tick();
    chk({tag, "_addr_e1"}, rom_address, 32'd0);
    chk({tag, "_valid_e1"}, 32'(id_valid), 32'd0);
    tick();
    chk({tag, "_addr_e2"}, rom_address, 32'd4);
    chk({tag, "_valid_e2"}, 32'(id_valid), 32'd1);
    tick();
    chk({tag, "_addr_e3"}, rom_address, 32'd8);
    tick();
    chk({tag, "_addr_e4"}, rom_address, 32'd12);
    tick();
    chk({tag, "_addr_e5"}, rom_address, 32'd16);
    tick();
    chk({tag, "_addr_e6"}, rom_address, 32'd20);
    id_ready = 1'b0;
    tick();
    chk({tag, "_addr_e7"}, rom_address, 32'd24);
    tick();
    chk({tag, "_addr_stall"}, rom_address, 32'd24);
    chk({tag, "_full_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every accepted head against the scoreboard; empty head must read zero.
  always @(negedge clock) begin
    if (id_valid && id_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got pc_plus4 %h instr %h expected no entry",
                 id_pc_plus4, id_instruction);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_instruction", id_instruction, mon_e.instruction);
        chk("pop_pc_plus4", id_pc_plus4, mon_e.pc_plus4);
      end
    end else if (!id_valid) begin
      chk("empty_instruction", id_instruction, 32'h0);
      chk("empty_pc_plus4", id_pc_plus4, 32'h0);
    end
  end

  initial begin
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk_reset_values("por");

    // Boot with a streaming decoder.
    boot_seq("boot1");

    // Asynchronous reset with the queue full, then an identical boot.
    #2 reset = 1'b1;
    #1;
    chk_reset_values("async_rst");
    boot_seq("boot2");

    // Stall from the first valid cycle, then drain.
    #2 reset = 1'b1;
    tick();
    id_ready = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    chk("stall_addr_e2", rom_address, 32'd4);
    tick();
    chk("stall_addr_e3", rom_address, 32'd8);
    tick();
    chk("stall_addr_e4", rom_address, 32'd8);
    chk("stall_valid", 32'(id_valid), 32'd1);
    tick();
    chk("stall_addr_e5", rom_address, 32'd8);
    push_exp(32'h8001_060A, 32'd4);
    push_exp(32'h0000_0000, 32'd8);
    push_exp(32'h0000_0000, 32'd12);
    id_ready = 1'b1;
    tick();
    chk("resume_addr", rom_address, 32'd12);
    tick();
    chk("resume_addr2", rom_address, 32'd16);
    tick();
    chk("resume_addr3", rom_address, 32'd20);

    // Redirect to 0x58 with a full queue and decode stalled.
    id_ready    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0058;
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    tick();
    redirect = 1'b0;
    chk("redir58_addr", rom_address, 32'h58);
    chk("redir58_bubble", 32'(id_valid), 32'd0);
    push_exp(32'hA500_0058, 32'h5C);
    id_ready = 1'b1;
    tick();
    chk("redir58_next_addr", rom_address, 32'h5C);
    chk("redir58_valid", 32'(id_valid), 32'd1);
    tick();
    chk("redir58_addr3", rom_address, 32'h60);

    // Misaligned target is forced to a word boundary.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0123;
    tick();
    chk("redir123_addr", rom_address, 32'h120);
    chk("redir123_bubble", 32'(id_valid), 32'd0);

    // Redirect to the top of the address space; the PC wraps to 0.
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("redir_top_addr", rom_address, 32'hFFFF_FFFC);
    chk("redir_top_bubble", 32'(id_valid), 32'd0);
    push_exp(32'h5AFF_FFFC, 32'h0);
    push_exp(32'h8001_060A, 32'd4);
    tick();
    chk("wrap_addr", rom_address, 32'h0);
    tick();
    chk("wrap_addr2", rom_address, 32'h4);
    tick();
    id_ready = 1'b0;
    chk("wrap_addr3", rom_address, 32'h8);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while still in BOOT: PC loads and fetch starts on the next edge.
    #2 reset = 1'b1;
    tick();
    reset       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    chk("boot_redir_addr", rom_address, 32'h40);
    chk("boot_redir_valid", 32'(id_valid), 32'd0);
    tick();
    chk("boot_redir_fetch_addr", rom_address, 32'h44);
    chk("boot_redir_head_valid", 32'(id_valid), 32'd1);
    chk("boot_redir_head_instr", id_instruction, 32'hA500_0040);
    chk("boot_redir_head_pc4", id_pc_plus4, 32'h44);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
